// File: rtl/hvac_pkg.sv
// hvac_pkg: state encoding and fan-speed constants shared by the HVAC zone
// controller files.
package hvac_pkg;

  // Controller state encoding (also driven out on state_o).
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COOL  = 2'd1;
  localparam logic [1:0] HEAT  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_COOL  = COOL,
    ST_HEAT  = HEAT,
    ST_FAULT = FAULT
  } hvac_state_e;

  // Fan-speed end points; intermediate speeds only exist with the fan option.
  localparam logic [1:0] FAN_OFF = 2'd0;
  localparam logic [1:0] FAN_MAX = 2'd3;

  // Larger of two elaboration-time integers (sizes the shared dwell counter).
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hvac_zone_ctrl_if.sv
// hvac_zone_ctrl_if: sensor sample/valid inputs and actuator/status outputs of
// the zone controller. The master side is the sensor/actuator harness, the
// slave side is the controller itself.
interface hvac_zone_ctrl_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] sensor;
  logic              sensor_valid;
  logic              cooler;
  logic              heater;
  logic [1:0]        fan_speed;
  logic              fault;
  logic [1:0]        state_o;

  modport master (
    output sensor, sensor_valid,
    input  cooler, heater, fan_speed, fault, state_o
  );

  modport slave (
    input  sensor, sensor_valid,
    output cooler, heater, fan_speed, fault, state_o
  );

endinterface

// File: rtl/hvac_dwell_timer.sv
// hvac_dwell_timer: saturating up-counter with synchronous clear. Counts one
// per clock from 0 and holds at MAX until cleared.
module hvac_dwell_timer #(
  parameter  int MAX = 4,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_reg;

  // Clear has priority; otherwise count up and stick at MAX.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (cnt_reg != MAX_C) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/hvac_zone_ctrl.sv
// hvac_zone_ctrl: single-zone heat/cool controller with hysteresis,
// anti-short-cycle dwell minimums, stale-sensor fault and fan-speed output.
// Optional build macro HVAC_FAN_SPEED_EN: graded fan speed from the last valid
// sample; without it the fan simply runs at full speed in COOL/HEAT.
module hvac_zone_ctrl
  import hvac_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int HOT_ON   = 35,
  parameter int HOT_OFF  = 25,
  parameter int COLD_ON  = 15,
  parameter int COLD_OFF = 30,
  parameter int MIN_ON   = 4,
  parameter int MIN_OFF  = 4,
  parameter int TIMEOUT  = 16,
  parameter int FAN_STEP = 5
) (
  input  logic                clk,
  input  logic                rstn,
  hvac_zone_ctrl_if.slave     bus
);

  localparam int DWELL_MAX = max_int(MIN_ON, MIN_OFF);
  localparam int DW        = $clog2(DWELL_MAX + 1);
  localparam int SW        = $clog2(TIMEOUT + 1);

  localparam logic [DATA_W-1:0] HOT_ON_C   = DATA_W'(HOT_ON);
  localparam logic [DATA_W-1:0] HOT_OFF_C  = DATA_W'(HOT_OFF);
  localparam logic [DATA_W-1:0] COLD_ON_C  = DATA_W'(COLD_ON);
  localparam logic [DATA_W-1:0] COLD_OFF_C = DATA_W'(COLD_OFF);
  localparam logic [DW-1:0]     MIN_ON_C   = DW'(MIN_ON);
  localparam logic [DW-1:0]     MIN_OFF_C  = DW'(MIN_OFF);
  localparam logic [SW-1:0]     STALE_LAST = SW'(TIMEOUT - 1);

  // Reject parameter sets that would make the hysteresis or timers meaningless.
  if (HOT_OFF >= HOT_ON) begin : g_chk_hot
    $fatal(1, "hvac_zone_ctrl: HOT_OFF must be below HOT_ON");
  end
  if (COLD_ON >= COLD_OFF) begin : g_chk_cold
    $fatal(1, "hvac_zone_ctrl: COLD_ON must be below COLD_OFF");
  end
  if (COLD_ON >= HOT_ON) begin : g_chk_band
    $fatal(1, "hvac_zone_ctrl: COLD_ON must be below HOT_ON");
  end
  if (MIN_ON < 1 || MIN_OFF < 1) begin : g_chk_dwell
    $fatal(1, "hvac_zone_ctrl: MIN_ON and MIN_OFF must be at least 1");
  end
  if (TIMEOUT < 2) begin : g_chk_timeout
    $fatal(1, "hvac_zone_ctrl: TIMEOUT must be at least 2");
  end
  if (FAN_STEP < 1) begin : g_chk_fan
    $fatal(1, "hvac_zone_ctrl: FAN_STEP must be at least 1");
  end

  hvac_state_e   state_reg;
  hvac_state_e   state_next;
  logic [DW-1:0] dwell_cnt;
  logic [SW-1:0] stale_cnt;
  logic          dwell_clr;
  logic          stale_timeout;

  // Dwell restarts on every state change so each state's minimum is measured
  // from its own entry edge.
  assign dwell_clr = (state_next != state_reg);

  hvac_dwell_timer #(.MAX(DWELL_MAX)) u_dwell (
    .clk  (clk),
    .rstn (rstn),
    .clr  (dwell_clr),
    .cnt  (dwell_cnt)
  );

  // Stale counter runs only across consecutive missing samples.
  hvac_dwell_timer #(.MAX(TIMEOUT)) u_stale (
    .clk  (clk),
    .rstn (rstn),
    .clr  (bus.sensor_valid),
    .cnt  (stale_cnt)
  );

  // TIMEOUT-th missing sample in a row forces FAULT at the coming edge.
  assign stale_timeout = !bus.sensor_valid && (stale_cnt >= STALE_LAST);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: thresholds act only on valid samples; timeout overrides dwell.
  always_comb begin
    state_next = state_reg;
    if (!bus.sensor_valid) begin
      if (stale_timeout) begin
        state_next = ST_FAULT;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.sensor > HOT_ON_C && dwell_cnt >= MIN_OFF_C) begin
            state_next = ST_COOL;
          end else if (bus.sensor < COLD_ON_C && dwell_cnt >= MIN_OFF_C) begin
            state_next = ST_HEAT;
          end
        end
        ST_COOL: begin
          if (bus.sensor < HOT_OFF_C && dwell_cnt >= MIN_ON_C) begin
            state_next = ST_IDLE;
          end
        end
        ST_HEAT: begin
          if (bus.sensor > COLD_OFF_C && dwell_cnt >= MIN_ON_C) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.state_o = state_reg;
  assign bus.cooler  = (state_reg == ST_COOL);
  assign bus.heater  = (state_reg == ST_HEAT);
  assign bus.fault   = (state_reg == ST_FAULT);

`ifdef HVAC_FAN_SPEED_EN
  localparam logic [DATA_W:0] STEP1_C = (DATA_W + 1)'(FAN_STEP);
  localparam logic [DATA_W:0] STEP2_C = (DATA_W + 1)'(2 * FAN_STEP);

  logic [DATA_W-1:0] last_reg;
  logic [DATA_W:0]   fan_d;
  logic [1:0]        fan_next;
  logic [1:0]        fan_reg;

  // Hold the most recent valid sample; only the fan grading consumes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_reg <= '0;
    end else if (bus.sensor_valid) begin
      last_reg <= bus.sensor;
    end
  end

  // Grade the fan by distance from the off-threshold; a negative distance
  // (sample already past the threshold) still runs the fan at its lowest speed.
  always_comb begin
    fan_d    = '0;
    fan_next = FAN_OFF;
    if (state_next == ST_COOL || state_next == ST_HEAT) begin
      if (state_next == ST_COOL) begin
        fan_d = {1'b0, last_reg} - {1'b0, HOT_OFF_C};
      end else begin
        fan_d = {1'b0, COLD_OFF_C} - {1'b0, last_reg};
      end
      if (fan_d[DATA_W] || fan_d < STEP1_C) begin
        fan_next = 2'd1;
      end else if (fan_d < STEP2_C) begin
        fan_next = 2'd2;
      end else begin
        fan_next = FAN_MAX;
      end
    end
  end

  // Registered fan speed, aligned with the state it belongs to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fan_reg <= FAN_OFF;
    end else begin
      fan_reg <= fan_next;
    end
  end

  assign bus.fan_speed = fan_reg;
`else
  assign bus.fan_speed = (state_reg == ST_COOL || state_reg == ST_HEAT) ? FAN_MAX : FAN_OFF;
`endif

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// tb_hvac_zone_ctrl: scenario-driven scoreboard bench for hvac_zone_ctrl with
// default parameters. Each stimulus cycle pushes the expected post-edge outputs
// and the value is popped and compared one time unit after the edge.
module tb_hvac_zone_ctrl;

  localparam logic [1:0] B_IDLE  = 2'd0;
  localparam logic [1:0] B_COOL  = 2'd1;
  localparam logic [1:0] B_HEAT  = 2'd2;
  localparam logic [1:0] B_FAULT = 2'd3;

  typedef struct packed {
    logic [1:0] st;
    logic       cool;
    logic       heat;
    logic       flt;
    logic [1:0] fan;
  } outs_t;

  typedef struct packed {
    logic [7:0] s;
    logic       v;
    logic [1:0] st;
    int         n;
  } stim_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  hvac_zone_ctrl_if #(.DATA_W(8)) bus ();

  hvac_zone_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  outs_t      exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] tb_last     = 8'd0;

  // Expected fan speed for a state, given the last valid sample before the edge.
  function automatic logic [1:0] exp_fan(input logic [1:0] st, input logic [7:0] last);
`ifdef HVAC_FAN_SPEED_EN
    int d;
    if (st == B_COOL) d = int'(last) - 25;
    else if (st == B_HEAT) d = 30 - int'(last);
    else return 2'd0;
    if (d < 5) return 2'd1;
    if (d < 10) return 2'd2;
    return 2'd3;
`else
    return (st == B_COOL || st == B_HEAT) ? 2'd3 : 2'd0;
`endif
  endfunction

  function automatic outs_t sample();
    return {bus.state_o, bus.cooler, bus.heater, bus.fault, bus.fan_speed};
  endfunction

  // Apply one cycle of stimulus and queue the outputs expected after the edge.
  task automatic drive(input logic [7:0] s, input logic v, input logic [1:0] st);
    outs_t e;
    bus.sensor       = s;
    bus.sensor_valid = v;
    e.st   = st;
    e.cool = (st == B_COOL);
    e.heat = (st == B_HEAT);
    e.flt  = (st == B_FAULT);
    e.fan  = exp_fan(st, tb_last);
    exp_q.push_back(e);
    if (v) tb_last = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn             = 1'b0;
    bus.sensor       = 8'd0;
    bus.sensor_valid = 1'b0;
    tb_last          = 8'd0;
    #2;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    outs_t e, g;
    rstn             = 1'b0;
    bus.sensor       = 8'd40;
    bus.sensor_valid = 1'b1;
    tb_last          = 8'd0;
    #1;
    exp_q.push_back('0);
    g = sample(); e = exp_q.pop_front(); vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL reset_now: got %b, expected %b", g, e);
    end
    @(posedge clk);
    #1;
    exp_q.push_back('0);
    g = sample(); e = exp_q.pop_front(); vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL reset_held: got %b, expected %b", g, e);
    end
    $display("reset: outputs held at zero while rstn low");
    #2;
    rstn = 1'b1;
  endtask

  task automatic test_idle_hold();
    stim_t tbl[1];
    outs_t e, g;
    tbl = '{'{8'd20, 1'b1, B_IDLE, 10}};
    do_reset();
    foreach (tbl[k]) for (int r = 0; r < tbl[k].n; r++) begin
      drive(tbl[k].s, tbl[k].v, tbl[k].st);
      g = sample(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL idle_hold row%0d cyc%0d: got %b, expected %b", k, r, g, e);
      end
      $display("idle_hold: sensor=%0d valid=%0d -> %b", tbl[k].s, tbl[k].v, g);
    end
  endtask

  task automatic test_cool();
    stim_t tbl[11];
    outs_t e, g;
    tbl = '{'{8'd40, 1'b1, B_IDLE, 4}, '{8'd40, 1'b1, B_COOL, 3},
            '{8'd20, 1'b1, B_COOL, 2}, '{8'd20, 1'b1, B_IDLE, 1},
            '{8'd40, 1'b1, B_IDLE, 4}, '{8'd40, 1'b1, B_COOL, 1},
            '{8'd28, 1'b1, B_COOL, 2}, '{8'd29, 1'b1, B_COOL, 2},
            '{8'd30, 1'b1, B_COOL, 2}, '{8'd33, 1'b1, B_COOL, 2},
            '{8'd40, 1'b1, B_COOL, 2}};
    do_reset();
    foreach (tbl[k]) for (int r = 0; r < tbl[k].n; r++) begin
      drive(tbl[k].s, tbl[k].v, tbl[k].st);
      g = sample(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL cool row%0d cyc%0d: got %b, expected %b", k, r, g, e);
      end
      $display("cool: sensor=%0d valid=%0d -> %b", tbl[k].s, tbl[k].v, g);
    end
  endtask

  task automatic test_heat();
    stim_t tbl[7];
    outs_t e, g;
    tbl = '{'{8'd10, 1'b1, B_IDLE, 4}, '{8'd10, 1'b1, B_HEAT, 1},
            '{8'd28, 1'b1, B_HEAT, 2}, '{8'd31, 1'b1, B_HEAT, 2},
            '{8'd31, 1'b1, B_IDLE, 1}, '{8'd0, 1'b0, B_IDLE, 15},
            '{8'd0, 1'b0, B_FAULT, 1}};
    do_reset();
    foreach (tbl[k]) for (int r = 0; r < tbl[k].n; r++) begin
      drive(tbl[k].s, tbl[k].v, tbl[k].st);
      g = sample(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL heat row%0d cyc%0d: got %b, expected %b", k, r, g, e);
      end
      $display("heat: sensor=%0d valid=%0d -> %b", tbl[k].s, tbl[k].v, g);
    end
  endtask

  task automatic test_thresholds();
    stim_t tbl[10];
    outs_t e, g;
    tbl = '{'{8'd35, 1'b1, B_IDLE, 6}, '{8'd15, 1'b1, B_IDLE, 2},
            '{8'd36, 1'b1, B_COOL, 1}, '{8'd25, 1'b1, B_COOL, 5},
            '{8'd24, 1'b1, B_IDLE, 1}, '{8'd10, 1'b1, B_IDLE, 4},
            '{8'd14, 1'b1, B_HEAT, 1}, '{8'd30, 1'b1, B_HEAT, 5},
            '{8'd31, 1'b1, B_IDLE, 1}, '{8'd20, 1'b1, B_IDLE, 2}};
    do_reset();
    foreach (tbl[k]) for (int r = 0; r < tbl[k].n; r++) begin
      drive(tbl[k].s, tbl[k].v, tbl[k].st);
      g = sample(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL thresholds row%0d cyc%0d: got %b, expected %b", k, r, g, e);
      end
      $display("thresholds: sensor=%0d valid=%0d -> %b", tbl[k].s, tbl[k].v, g);
    end
  endtask

  task automatic test_no_direct();
    stim_t tbl[5];
    outs_t e, g;
    tbl = '{'{8'd40, 1'b1, B_IDLE, 4}, '{8'd40, 1'b1, B_COOL, 1},
            '{8'd10, 1'b1, B_COOL, 4}, '{8'd10, 1'b1, B_IDLE, 5},
            '{8'd10, 1'b1, B_HEAT, 1}};
    do_reset();
    foreach (tbl[k]) for (int r = 0; r < tbl[k].n; r++) begin
      drive(tbl[k].s, tbl[k].v, tbl[k].st);
      g = sample(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL no_direct row%0d cyc%0d: got %b, expected %b", k, r, g, e);
      end
      $display("no_direct: sensor=%0d valid=%0d -> %b", tbl[k].s, tbl[k].v, g);
    end
  endtask

  task automatic test_timeout();
    stim_t tbl[11];
    outs_t e, g;
    tbl = '{'{8'd40, 1'b1, B_IDLE, 4}, '{8'd40, 1'b1, B_COOL, 1},
            '{8'd0, 1'b0, B_COOL, 15}, '{8'd0, 1'b0, B_FAULT, 2},
            '{8'd20, 1'b1, B_IDLE, 1}, '{8'd40, 1'b1, B_IDLE, 4},
            '{8'd40, 1'b1, B_COOL, 1}, '{8'd0, 1'b0, B_COOL, 15},
            '{8'd40, 1'b1, B_COOL, 1}, '{8'd0, 1'b0, B_COOL, 15},
            '{8'd40, 1'b1, B_COOL, 1}};
    do_reset();
    foreach (tbl[k]) for (int r = 0; r < tbl[k].n; r++) begin
      drive(tbl[k].s, tbl[k].v, tbl[k].st);
      g = sample(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL timeout row%0d cyc%0d: got %b, expected %b", k, r, g, e);
      end
      $display("timeout: sensor=%0d valid=%0d -> %b", tbl[k].s, tbl[k].v, g);
    end
  endtask

  // Rows with n==0 assert rstn mid-cycle and check the outputs before any edge.
  task automatic test_async_reset();
    stim_t tbl[5];
    outs_t e, g;
    tbl = '{'{8'd40, 1'b1, B_IDLE, 4}, '{8'd40, 1'b1, B_COOL, 2},
            '{8'd40, 1'b1, B_IDLE, 0},
            '{8'd40, 1'b1, B_IDLE, 4}, '{8'd40, 1'b1, B_COOL, 1}};
    do_reset();
    foreach (tbl[k]) begin
      if (tbl[k].n == 0) begin
        rstn = 1'b0;
        #2;
        exp_q.push_back('0);
        tb_last = 8'd0;
        g = sample(); e = exp_q.pop_front(); vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL async_reset mid-cycle: got %b, expected %b", g, e);
        end
        $display("async_reset: rstn low mid-cycle -> %b", g);
        rstn = 1'b1;
      end
      for (int r = 0; r < tbl[k].n; r++) begin
        drive(tbl[k].s, tbl[k].v, tbl[k].st);
        g = sample(); e = exp_q.pop_front(); vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL async_reset row%0d cyc%0d: got %b, expected %b", k, r, g, e);
        end
        $display("async_reset: sensor=%0d valid=%0d -> %b", tbl[k].s, tbl[k].v, g);
      end
    end
  endtask

  initial begin
    bus.sensor       = 8'd0;
    bus.sensor_valid = 1'b0;
    test_reset();
    test_idle_hold();
    test_cool();
    test_heat();
    test_thresholds();
    test_no_direct();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
